regfile_write_scheduler: RTL and testbench
==========================================

// Module: regfile_write_scheduler
// PURPOSE
//   Shares the single register-file write port among NUM_REQ writeback sources
//   (e.g. ALU, load unit, multiplier) using round-robin or fixed-priority arbitration.
//   Drives the register file's ctrl_reg_write/write_reg/write_data through a 1-cycle
//   output register. Keeps a busy scoreboard of destination registers with a pending
//   writeback, and reports read hazards for the two read-port addresses to the issue stage.
// PARAMETERS
//   NUM_REQ   3   number of writeback requesters (2..8)
//   DATA_W    16  write data width (must match register file)
//   ADDR_W    4   register address width; scoreboard has 2**ADDR_W entries
//   FIXED_PRI 0   0 = round-robin; 1 = fixed priority, lowest index wins
// PORTS
//   clk            in  1               clock, all state updates on posedge
//   rst            in  1               synchronous reset, active-high
//   req_valid      in  NUM_REQ         requester i has a writeback pending
//   req_reg        in  NUM_REQ*ADDR_W  dest reg of requester i, bits [ADDR_W*i +: ADDR_W]
//   req_data       in  NUM_REQ*DATA_W  data of requester i, bits [DATA_W*i +: DATA_W]
//   req_ready      out NUM_REQ         grant; transfer when req_valid[i] & req_ready[i]
//   alloc_valid    in  1               issue stage claims a dest reg for a future writeback
//   alloc_reg      in  ADDR_W          reg being claimed
//   flush          in  1               clear scoreboard (pipeline flush)
//   read_reg1      in  ADDR_W          read-port-1 address being issued
//   read_reg2      in  ADDR_W          read-port-2 address being issued
//   rd1_busy       out 1               busy[read_reg1], combinational
//   rd2_busy       out 1               busy[read_reg2], combinational
//   busy_vec       out 2**ADDR_W       full scoreboard, registered
//   ctrl_reg_write out 1               to register file write enable
//   write_reg      out ADDR_W          to register file write address
//   write_data     out DATA_W          to register file write data
// BEHAVIOUR
//   Reset (rst=1 at posedge): ctrl_reg_write=0, write_reg=0, write_data=0, busy_vec=0,
//     RR pointer=0. rst overrides all inputs, including mid-transfer. req_ready=0 while rst=1.
//   Arbitration (combinational, each cycle):
//     - At most one req_ready bit high, and only for a requester with req_valid=1.
//     - If no req_valid is high, req_ready=0.
//     - RR: search from pointer p upward, wrapping at NUM_REQ. First valid index wins.
//     - After a grant to index g, p <= (g+1) mod NUM_REQ. p holds when there is no grant.
//     - FIXED_PRI=1: lowest valid index wins; p is unused.
//     - req_ready must not depend on req_data/req_reg.
//   Write stage (1-cycle latency):
//     - Grant at edge N gives ctrl_reg_write=1 with captured reg/data during cycle N+1.
//     - The register file commits at edge N+1.
//     - No grant gives ctrl_reg_write=0; write_reg/write_data hold their last values.
//     - Every cycle can issue a write; sustained throughput is 1 write/cycle.
//   Scoreboard:
//     - Set: alloc_valid=1 sets busy[alloc_reg] at the next edge.
//     - Clear: a granted transfer clears busy[req_reg of winner] at the same edge it is
//       captured, so a hazard drops the cycle the write is driven to the register file.
//     - Set and clear on the same reg in the same cycle: set wins (a newer producer exists).
//     - flush=1: busy_vec <= 0. A simultaneous alloc is dropped; an in-flight write still
//       completes.
//     - Writes to a non-busy reg are legal and leave its busy bit at 0.
//   Ordering:
//     - Same-reg requests from different requesters commit in grant order.
//     - Requesters must hold valid/reg/data stable until granted.
// TESTING
//   1. Reset: rst=1 for 2 cycles with all req_valid=1 -> req_ready=0, ctrl_reg_write=0,
//      busy_vec=0.
//   2. RR fairness: all 3 valid continuously -> grants 0,1,2,0,1,2; ctrl_reg_write=1 every
//      cycle from the cycle after the first grant.
//   3. Latency: req1 valid reg=5 data=16'hBEEF at edge N -> cycle N+1 shows ctrl_reg_write=1,
//      write_reg=5, write_data=16'hBEEF; cycle N+2 shows 0.
//   4. Scoreboard: alloc reg 7, then read_reg1=7 -> rd1_busy=1 until the edge granting a
//      reg-7 write, then 0.
//   5. Same-cycle alloc reg 3 and grant of write to reg 3 -> busy[3]=1 afterwards.
//      flush with alloc reg 4 -> busy_vec=0.
//   6. FIXED_PRI=1, requesters 0 and 2 always valid -> 0 granted every cycle, 2 starves.
//      Drop req0 -> 2 granted next cycle.

Source files
------------

// File: rtl/regfile_write_scheduler.sv
// Register-file write-port scheduler: arbitrates NUM_REQ writeback sources onto the
// single write port through a one-cycle output register, and keeps a busy scoreboard
// of destination registers so the issue stage can detect read hazards.
module regfile_write_scheduler #(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned FIXED_PRI = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_reg,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        alloc_valid,
    input  logic [ADDR_W-1:0]           alloc_reg,
    input  logic                        flush,
    input  logic [ADDR_W-1:0]           read_reg1,
    input  logic [ADDR_W-1:0]           read_reg2,
    output logic                        rd1_busy,
    output logic                        rd2_busy,
    output logic [(2**ADDR_W)-1:0]      busy_vec,
    output logic                        ctrl_reg_write,
    output logic [ADDR_W-1:0]           write_reg,
    output logic [DATA_W-1:0]           write_data
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;
    localparam int unsigned PtrW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Round-robin search order: offset k from the pointer, wrapping at NUM_REQ.
    function automatic int unsigned search_idx(input int unsigned base, input int unsigned k);
        return (base + k) % NUM_REQ;
    endfunction

    logic [PtrW-1:0]     r_ptr;
    logic [PtrW-1:0]     w_ptr_next;
    logic [NUM_REQ-1:0]  w_grant;
    logic                w_win_valid;
    logic [PtrW-1:0]     w_win_idx;
    logic [ADDR_W-1:0]   w_win_reg;
    logic [DATA_W-1:0]   w_win_data;
    logic [NumRegs-1:0]  r_busy;
    logic [NumRegs-1:0]  w_busy_next;
    logic                r_write_en;
    logic [ADDR_W-1:0]   r_write_reg;
    logic [DATA_W-1:0]   r_write_data;

    // Arbiter: first valid requester from the search base wins; depends only on req_valid.
    always_comb begin
        w_grant     = '0;
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        if (!rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!w_win_valid &&
                    req_valid[search_idx((FIXED_PRI != 0) ? 0 : int'(r_ptr), k)]) begin
                    w_win_valid = 1'b1;
                    w_win_idx   = PtrW'(search_idx((FIXED_PRI != 0) ? 0 : int'(r_ptr), k));
                end
            end
            if (w_win_valid) begin
                w_grant[w_win_idx] = 1'b1;
            end
        end
    end

    assign w_win_reg  = req_reg[ADDR_W*w_win_idx +: ADDR_W];
    assign w_win_data = req_data[DATA_W*w_win_idx +: DATA_W];
    assign w_ptr_next = (w_win_idx == PtrW'(NUM_REQ - 1)) ? '0 : w_win_idx + PtrW'(1);

    // Round-robin pointer advances past the winner; holds when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_win_valid && (FIXED_PRI == 0)) begin
            r_ptr <= w_ptr_next;
        end
    end

    // Write output register: one-cycle latency; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write_en   <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else begin
            r_write_en <= w_win_valid;
            if (w_win_valid) begin
                r_write_reg  <= w_win_reg;
                r_write_data <= w_win_data;
            end
        end
    end

    // Scoreboard next state: clear on grant, then set on alloc (newer producer wins),
    // flush overrides both.
    always_comb begin
        w_busy_next = r_busy;
        if (w_win_valid) begin
            w_busy_next[w_win_reg] = 1'b0;
        end
        if (alloc_valid) begin
            w_busy_next[alloc_reg] = 1'b1;
        end
        if (flush) begin
            w_busy_next = '0;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign req_ready      = w_grant;
    assign rd1_busy       = r_busy[read_reg1];
    assign rd2_busy       = r_busy[read_reg2];
    assign busy_vec       = r_busy;
    assign ctrl_reg_write = r_write_en;
    assign write_reg      = r_write_reg;
    assign write_data     = r_write_data;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench: a round-robin instance and a fixed-priority instance share clock and reset.
module tb_regfile_write_scheduler;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ADDR_W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Round-robin instance signals
    logic [NUM_REQ-1:0]        rr_valid;
    logic [NUM_REQ*ADDR_W-1:0] rr_reg;
    logic [NUM_REQ*DATA_W-1:0] rr_data;
    logic [NUM_REQ-1:0]        rr_ready;
    logic                      alloc_valid;
    logic [ADDR_W-1:0]         alloc_reg;
    logic                      flush;
    logic [ADDR_W-1:0]         read_reg1, read_reg2;
    logic                      rd1_busy, rd2_busy;
    logic [15:0]               busy_vec;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_reg;
    logic [DATA_W-1:0]         wr_data;

    // Fixed-priority instance signals
    logic [NUM_REQ-1:0]        fp_valid;
    logic [NUM_REQ*ADDR_W-1:0] fp_reg;
    logic [NUM_REQ*DATA_W-1:0] fp_data;
    logic [NUM_REQ-1:0]        fp_ready;
    logic                      fp_rd1_busy, fp_rd2_busy;
    logic [15:0]               fp_busy_vec;
    logic                      fp_wr_en;
    logic [ADDR_W-1:0]         fp_wr_reg;
    logic [DATA_W-1:0]         fp_wr_data;

    regfile_write_scheduler #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIXED_PRI(0)
    ) u_rr (
        .clk(clk), .rst(rst),
        .req_valid(rr_valid), .req_reg(rr_reg), .req_data(rr_data), .req_ready(rr_ready),
        .alloc_valid(alloc_valid), .alloc_reg(alloc_reg), .flush(flush),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .rd1_busy(rd1_busy), .rd2_busy(rd2_busy), .busy_vec(busy_vec),
        .ctrl_reg_write(wr_en), .write_reg(wr_reg), .write_data(wr_data)
    );

    regfile_write_scheduler #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIXED_PRI(1)
    ) u_fp (
        .clk(clk), .rst(rst),
        .req_valid(fp_valid), .req_reg(fp_reg), .req_data(fp_data), .req_ready(fp_ready),
        .alloc_valid(1'b0), .alloc_reg(4'd0), .flush(1'b0),
        .read_reg1(4'd0), .read_reg2(4'd0),
        .rd1_busy(fp_rd1_busy), .rd2_busy(fp_rd2_busy), .busy_vec(fp_busy_vec),
        .ctrl_reg_write(fp_wr_en), .write_reg(fp_wr_reg), .write_data(fp_wr_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [ADDR_W-1:0] exp_reg [3];
    logic [DATA_W-1:0] exp_dat [3];

    initial begin
        exp_reg[0] = 4'd1; exp_reg[1] = 4'd2; exp_reg[2] = 4'd3;
        exp_dat[0] = 16'h1111; exp_dat[1] = 16'h2222; exp_dat[2] = 16'h3333;

        rr_valid = 3'b111;
        rr_reg   = {4'd3, 4'd2, 4'd1};
        rr_data  = {16'h3333, 16'h2222, 16'h1111};
        fp_valid = 3'b111;
        fp_reg   = {4'd12, 4'd11, 4'd10};
        fp_data  = {16'hCCCC, 16'hBBBB, 16'hAAAA};
        alloc_valid = 1'b0;
        alloc_reg   = '0;
        flush       = 1'b0;
        read_reg1   = '0;
        read_reg2   = '0;

        // 1. Reset with all requesters valid
        for (int c = 0; c < 2; c++) begin
            tick();
            check_eq("rst_ready", 32'(rr_ready), 32'h0);
            check_eq("rst_wr_en", 32'(wr_en), 32'h0);
            check_eq("rst_busy", 32'(busy_vec), 32'h0);
            check_eq("rst_fp_ready", 32'(fp_ready), 32'h0);
        end
        check_eq("rst_wr_reg", 32'(wr_reg), 32'h0);
        check_eq("rst_wr_data", 32'(wr_data), 32'h0);
        rst      = 1'b0;
        fp_valid = 3'b000;
        #1;

        // 2. Round-robin fairness with all three valid
        for (int i = 0; i < 6; i++) begin
            check_eq("rr_grant", 32'(rr_ready), 32'(3'b001 << (i % 3)));
            tick();
            check_eq("rr_wr_en", 32'(wr_en), 32'h1);
            check_eq("rr_wr_reg", 32'(wr_reg), 32'(exp_reg[i % 3]));
            check_eq("rr_wr_data", 32'(wr_data), 32'(exp_dat[i % 3]));
        end
        rr_valid = 3'b000;
        #1;
        check_eq("idle_ready", 32'(rr_ready), 32'h0);
        tick();
        check_eq("idle_wr_en", 32'(wr_en), 32'h0);
        check_eq("hold_wr_reg", 32'(wr_reg), 32'h3);
        check_eq("hold_wr_data", 32'(wr_data), 32'h3333);
        check_eq("nonbusy_write", 32'(busy_vec), 32'h0);

        // 3. Latency: requester 1, reg 5, data BEEF (pointer is back at 0)
        rr_valid = 3'b010;
        rr_reg   = {4'd0, 4'd5, 4'd0};
        rr_data  = {16'h0000, 16'hBEEF, 16'h0000};
        #1;
        check_eq("lat_grant", 32'(rr_ready), 32'h2);
        tick();
        rr_valid = 3'b000;
        check_eq("lat_wr_en", 32'(wr_en), 32'h1);
        check_eq("lat_wr_reg", 32'(wr_reg), 32'h5);
        check_eq("lat_wr_data", 32'(wr_data), 32'hBEEF);
        tick();
        check_eq("lat_wr_en_off", 32'(wr_en), 32'h0);

        // 4. Scoreboard set / hazard / clear on grant (pointer now 2)
        alloc_valid = 1'b1;
        alloc_reg   = 4'd7;
        read_reg1   = 4'd7;
        read_reg2   = 4'd7;
        #1;
        check_eq("sb_pre_alloc", 32'(rd1_busy), 32'h0);
        tick();
        alloc_valid = 1'b0;
        check_eq("sb_rd1_busy", 32'(rd1_busy), 32'h1);
        check_eq("sb_rd2_busy", 32'(rd2_busy), 32'h1);
        check_eq("sb_busy_vec", 32'(busy_vec), 32'h0080);
        tick();
        check_eq("sb_busy_hold", 32'(rd1_busy), 32'h1);
        rr_valid = 3'b100;
        rr_reg   = {4'd7, 4'd0, 4'd0};
        rr_data  = {16'h7777, 16'h0000, 16'h0000};
        #1;
        check_eq("sb_grant2", 32'(rr_ready), 32'h4);
        check_eq("sb_busy_pregrant", 32'(rd1_busy), 32'h1);
        tick();
        rr_valid = 3'b000;
        check_eq("sb_cleared", 32'(rd1_busy), 32'h0);
        check_eq("sb_wr_reg", 32'(wr_reg), 32'h7);
        check_eq("sb_wr_en", 32'(wr_en), 32'h1);

        // 5. Same-cycle alloc and write to reg 3: set wins (pointer now 0)
        alloc_valid = 1'b1;
        alloc_reg   = 4'd3;
        rr_valid    = 3'b001;
        rr_reg      = {4'd0, 4'd0, 4'd3};
        rr_data     = {16'h0000, 16'h0000, 16'h0333};
        tick();
        alloc_valid = 1'b0;
        rr_valid    = 3'b000;
        check_eq("setwins_busy", 32'(busy_vec), 32'h0008);
        check_eq("setwins_wr_reg", 32'(wr_reg), 32'h3);
        // flush with simultaneous alloc and an in-flight write
        flush       = 1'b1;
        alloc_valid = 1'b1;
        alloc_reg   = 4'd4;
        rr_valid    = 3'b010;
        rr_reg      = {4'd0, 4'd9, 4'd0};
        rr_data     = {16'h0000, 16'h0999, 16'h0000};
        tick();
        flush       = 1'b0;
        alloc_valid = 1'b0;
        rr_valid    = 3'b000;
        check_eq("flush_busy", 32'(busy_vec), 32'h0);
        check_eq("flush_wr_en", 32'(wr_en), 32'h1);
        check_eq("flush_wr_reg", 32'(wr_reg), 32'h9);
        check_eq("flush_wr_data", 32'(wr_data), 32'h0999);
        tick();
        check_eq("flush_busy_after", 32'(busy_vec), 32'h0);

        // 6. Fixed priority: 0 and 2 valid, 2 starves until 0 drops
        fp_valid = 3'b101;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("fp_grant0", 32'(fp_ready), 32'h1);
            tick();
            check_eq("fp_wr_reg0", 32'(fp_wr_reg), 32'd10);
        end
        fp_valid = 3'b100;
        #1;
        check_eq("fp_grant2", 32'(fp_ready), 32'h4);
        tick();
        fp_valid = 3'b000;
        check_eq("fp_wr_reg2", 32'(fp_wr_reg), 32'd12);
        check_eq("fp_wr_data2", 32'(fp_wr_data), 32'hCCCC);

        // Reset mid-transfer overrides valid requests
        rr_valid = 3'b111;
        rst      = 1'b1;
        #1;
        check_eq("midrst_ready", 32'(rr_ready), 32'h0);
        tick();
        check_eq("midrst_wr_en", 32'(wr_en), 32'h0);
        check_eq("midrst_wr_reg", 32'(wr_reg), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
